// File: rtl/gb_mem_responder_if.sv
// Generic bus: a requester drives addr/wdata/byte_en/ren/wen and waits while
// busy is high; the responder returns rdata and drops busy for one cycle to
// complete the access.
//   addr[31:0]    byte address
//   wdata[31:0]   write data
//   byte_en[3:0]  byte lane enables for writes
//   ren, wen      read / write request
//   rdata[31:0]   read data, valid in the busy=0 cycle
//   busy          high while the responder has not completed the access
interface generic_bus_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  byte_en;
   logic        ren;
   logic        wen;
   logic [31:0] rdata;
   logic        busy;

   // Responder end
   modport generic_bus (
      input  addr,
      input  wdata,
      input  byte_en,
      input  ren,
      input  wen,
      output rdata,
      output busy
   );

   // Requester end
   modport cpu (
      output addr,
      output wdata,
      output byte_en,
      output ren,
      output wen,
      input  rdata,
      input  busy
   );
endinterface

// File: rtl/gb_mem_responder.sv
// Word-addressed memory behind a generic bus responder with a programmable
// number of wait states.
//   AFT_CLK     clock
//   nRST        asynchronous active-low reset
//   gbif        responder end of the generic bus (addr, wdata, byte_en,
//               ren, wen in; rdata, busy out)
//   err         sticky error: out-of-range access or ren&wen together
//   access_cnt  number of completed accesses, wraps at 16 bits
module gb_mem_responder #(
   parameter int unsigned DEPTH_LOG2  = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic               AFT_CLK,
   input  logic               nRST,
   generic_bus_if.generic_bus gbif,
   output logic               err,
   output logic [15:0]        access_cnt
);

   localparam int unsigned   DEPTH     = 1 << DEPTH_LOG2;
   localparam int unsigned   CNT_W     = 4;
   localparam int unsigned   AW        = 32;
   localparam int unsigned   DW        = 32;
   localparam int unsigned   BEW       = 4;
   localparam bit            ZERO_WAIT = (WAIT_STATES == 0);
   // Unreachable when WAIT_STATES is 0 because WAIT is never entered.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_STATES - 1);
   localparam logic [DW-1:0] BAD_WORD  = 32'hBAD1_BAD1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_wcnt;
   logic [AW-1:0]       r_addr;
   logic [DW-1:0]       r_wdata;
   logic [BEW-1:0]      r_be;
   logic                r_wr;
   logic                r_dual;
   logic                r_busy;
   logic [DW-1:0]       r_rdata;
   logic                r_err;
   logic [15:0]         r_cnt;
   logic [DW-1:0]       r_mem [DEPTH];

   logic                w_req;
   logic                w_in_idle;
   logic [AW-1:0]       w_addr;
   logic [DW-1:0]       w_wdata;
   logic [BEW-1:0]      w_be;
   logic                w_wr;
   logic                w_dual;
   logic                w_go_resp;
   logic [AW-1:0]       w_offset;
   logic                w_below;
   logic                w_above;
   logic                w_oor;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                w_commit;

   assign w_req     = gbif.ren | gbif.wen;
   assign w_in_idle = (r_state == IDLE);

   // With zero wait states the access completes on the edge that accepts it,
   // so the live bus values stand in for the not-yet-latched ones.
   assign w_addr  = w_in_idle ? gbif.addr    : r_addr;
   assign w_wdata = w_in_idle ? gbif.wdata   : r_wdata;
   assign w_be    = w_in_idle ? gbif.byte_en : r_be;
   assign w_wr    = w_in_idle ? gbif.wen     : r_wr;
   assign w_dual  = w_in_idle ? (gbif.ren & gbif.wen) : r_dual;

   // True on the clock edge that moves the FSM into RESP.
   assign w_go_resp = w_req &&
                      ((w_in_idle && ZERO_WAIT) ||
                       ((r_state == WAIT) && (r_wcnt == LAST_WAIT)));

   // Address decode: below the base, or past the last word.
   assign w_offset = w_addr - BASE_ADDR;
   assign w_below  = (w_addr < BASE_ADDR);
   assign w_above  = ((w_offset >> (DEPTH_LOG2 + 2)) != '0);
   assign w_oor    = w_below | w_above;
   assign w_idx    = w_offset[DEPTH_LOG2+1:2];

   // Reset held low suppresses a commit even if a zero-wait request is present.
   assign w_commit = nRST & w_go_resp & w_wr & ~w_oor;

   // Memory array: byte-lane writes, never reset.
   always_ff @(posedge AFT_CLK) begin
      if (w_commit) begin
         for (int i = 0; i < BEW; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   // Control FSM with registered busy, read data, error and access counter.
   always_ff @(posedge AFT_CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
         r_wcnt  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_wr    <= 1'b0;
         r_dual  <= 1'b0;
         r_busy  <= 1'b1;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_busy <= 1'b1;
               if (w_req) begin
                  r_addr  <= gbif.addr;
                  r_wdata <= gbif.wdata;
                  r_be    <= gbif.byte_en;
                  r_wr    <= gbif.wen;
                  r_dual  <= gbif.ren & gbif.wen;
                  r_wcnt  <= '0;
                  if (ZERO_WAIT) begin
                     r_state <= RESP;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // Requester withdrew: drop the access without side effects.
               if (!w_req) begin
                  r_state <= IDLE;
               end else if (r_wcnt == LAST_WAIT) begin
                  r_state <= RESP;
                  r_busy  <= 1'b0;
               end else begin
                  r_wcnt <= r_wcnt + CNT_W'(1);
               end
            end
            RESP: begin
               r_state <= IDLE;
               r_busy  <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b1;
            end
         endcase

         // Completion side effects become visible during the RESP cycle.
         if (w_go_resp) begin
            r_cnt <= r_cnt + 16'd1;
            if (w_oor || w_dual) r_err <= 1'b1;
            if (!w_wr) r_rdata <= w_oor ? BAD_WORD : r_mem[w_idx];
         end
      end
   end

   assign gbif.busy  = r_busy;
   assign gbif.rdata = r_rdata;
   assign err        = r_err;
   assign access_cnt = r_cnt;

endmodule

// File: tb/tb_gb_mem_responder.sv
// Bench for gb_mem_responder: two instances (two wait states at base 0 with
// 256 words, zero wait states at base 0x1000 with 16 words) driven by directed
// transactions and compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_gb_mem_responder;
   localparam int NDUT = 2;
   localparam int unsigned WS_A = 2;
   localparam int unsigned WS_B = 0;
   localparam logic [31:0] BASE_A = 32'h0000_0000;
   localparam logic [31:0] BASE_B = 32'h0000_1000;
   localparam int unsigned DL_A = 8;
   localparam int unsigned DL_B = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst_n;
   logic [31:0] t_addr  [NDUT];
   logic [31:0] t_wdata [NDUT];
   logic [3:0]  t_be    [NDUT];
   logic        t_ren   [NDUT];
   logic        t_wen   [NDUT];

   logic [31:0] o_rdata [NDUT];
   logic        o_busy  [NDUT];
   logic        o_err   [NDUT];
   logic [15:0] o_cnt   [NDUT];

   logic        err_a, err_b;
   logic [15:0] cnt_a, cnt_b;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   generic_bus_if bus_a ();
   generic_bus_if bus_b ();

   assign bus_a.addr    = t_addr[0];
   assign bus_a.wdata   = t_wdata[0];
   assign bus_a.byte_en = t_be[0];
   assign bus_a.ren     = t_ren[0];
   assign bus_a.wen     = t_wen[0];
   assign bus_b.addr    = t_addr[1];
   assign bus_b.wdata   = t_wdata[1];
   assign bus_b.byte_en = t_be[1];
   assign bus_b.ren     = t_ren[1];
   assign bus_b.wen     = t_wen[1];

   assign o_rdata[0] = bus_a.rdata;
   assign o_busy[0]  = bus_a.busy;
   assign o_err[0]   = err_a;
   assign o_cnt[0]   = cnt_a;
   assign o_rdata[1] = bus_b.rdata;
   assign o_busy[1]  = bus_b.busy;
   assign o_err[1]   = err_b;
   assign o_cnt[1]   = cnt_b;

   gb_mem_responder #(.DEPTH_LOG2(DL_A), .BASE_ADDR(BASE_A), .WAIT_STATES(WS_A)) u_dut_a (
      .AFT_CLK    (clk),
      .nRST       (rst_n[0]),
      .gbif       (bus_a),
      .err        (err_a),
      .access_cnt (cnt_a)
   );

   gb_mem_responder #(.DEPTH_LOG2(DL_B), .BASE_ADDR(BASE_B), .WAIT_STATES(WS_B)) u_dut_b (
      .AFT_CLK    (clk),
      .nRST       (rst_n[1]),
      .gbif       (bus_b),
      .err        (err_b),
      .access_cnt (cnt_b)
   );

   function automatic int ws_of(input int k);
      return (k == 0) ? int'(WS_A) : int'(WS_B);
   endfunction
   function automatic logic [31:0] base_of(input int k);
      return (k == 0) ? BASE_A : BASE_B;
   endfunction
   function automatic int unsigned words_of(input int k);
      return (k == 0) ? (32'd1 << DL_A) : (32'd1 << DL_B);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] m_mem [NDUT][256];
   int          m_left  [NDUT];   // wait cycles still owed, -1 when no access pending
   bit          m_resp  [NDUT];   // current cycle is the completion cycle
   logic [31:0] m_addr  [NDUT];
   logic [31:0] m_wdata [NDUT];
   logic [3:0]  m_be    [NDUT];
   bit          m_wr    [NDUT];
   bit          m_dual  [NDUT];
   logic [31:0] e_rdata [NDUT];
   bit          e_err   [NDUT];
   logic [15:0] e_cnt   [NDUT];

   task automatic model_reset(input int k);
      m_left[k]  = -1;
      m_resp[k]  = 1'b0;
      m_addr[k]  = '0;
      m_wdata[k] = '0;
      m_be[k]    = '0;
      m_wr[k]    = 1'b0;
      m_dual[k]  = 1'b0;
      e_rdata[k] = '0;
      e_err[k]   = 1'b0;
      e_cnt[k]   = '0;
   endtask

   task automatic model_complete(input int k);
      bit          oor;
      int unsigned off;
      oor = 1'b0;
      off = 0;
      if (m_addr[k] < base_of(k)) oor = 1'b1;
      else begin
         off = (m_addr[k] - base_of(k)) / 4;
         if (off >= words_of(k)) oor = 1'b1;
      end
      if (m_wr[k]) begin
         if (!oor)
            for (int b = 0; b < 4; b++)
               if (m_be[k][b]) m_mem[k][off][8*b +: 8] = m_wdata[k][8*b +: 8];
      end else begin
         e_rdata[k] = oor ? 32'hBAD1_BAD1 : m_mem[k][off];
      end
      if (oor || m_dual[k]) e_err[k] = 1'b1;
      e_cnt[k] = e_cnt[k] + 16'd1;
      m_resp[k] = 1'b1;
   endtask

   task automatic model_step(input int k);
      bit req;
      req = t_ren[k] | t_wen[k];
      if (!rst_n[k]) begin
         model_reset(k);
      end else if (m_resp[k]) begin
         m_resp[k] = 1'b0;
      end else if (m_left[k] < 0) begin
         if (req) begin
            m_addr[k]  = t_addr[k];
            m_wdata[k] = t_wdata[k];
            m_be[k]    = t_be[k];
            m_wr[k]    = t_wen[k];
            m_dual[k]  = t_ren[k] & t_wen[k];
            if (ws_of(k) == 0) model_complete(k);
            else m_left[k] = ws_of(k);
         end
      end else if (!req) begin
         m_left[k] = -1;
      end else begin
         m_left[k] = m_left[k] - 1;
         if (m_left[k] == 0) begin
            m_left[k] = -1;
            model_complete(k);
         end
      end
   endtask

   always @(posedge clk) for (int k = 0; k < NDUT; k++) model_step(k);
   always @(negedge rst_n[0]) model_reset(0);
   always @(negedge rst_n[1]) model_reset(1);

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < NDUT; k++) begin
            check($sformatf("busy dut%0d", k),  32'(o_busy[k]), 32'(!m_resp[k]));
            check($sformatf("rdata dut%0d", k), o_rdata[k], e_rdata[k]);
            check($sformatf("err dut%0d", k),   32'(o_err[k]), 32'(e_err[k]));
            check($sformatf("cnt dut%0d", k),   32'(o_cnt[k]), 32'(e_cnt[k]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called just after a rising edge with the DUT idle; returns the number of
   // cycles from the first request cycle to the busy=0 cycle and the outputs
   // seen in that cycle, then withdraws the request.
   task automatic txn(input int k, input bit wr, input bit rd, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, output int lat,
                      output logic [31:0] rdv, output logic [15:0] cntv, output bit errv);
      t_addr[k] = a; t_wdata[k] = d; t_be[k] = be; t_wen[k] = wr; t_ren[k] = rd;
      lat = 0;
      forever begin
         @(negedge clk);
         if (o_busy[k] == 1'b0) break;
         lat++;
         if (lat > 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn timeout dut%0d addr %h", k, a);
            break;
         end
      end
      rdv = o_rdata[k]; cntv = o_cnt[k]; errv = o_err[k];
      @(posedge clk); #1;
      t_ren[k] = 1'b0; t_wen[k] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          nlow;
      logic [31:0] rdv;
      logic [15:0] cv;
      bit          ev;
      logic [4:0]  pat;

      rst_n = 2'b00;
      for (int k = 0; k < NDUT; k++) begin
         t_addr[k] = '0; t_wdata[k] = '0; t_be[k] = '0; t_ren[k] = 1'b0; t_wen[k] = 1'b0;
         model_reset(k);
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", 32'(o_busy[0]), 32'd1);
      check("reset rdata", o_rdata[0], 32'h0);
      check("reset err", 32'(o_err[0]), 32'd0);
      check("reset cnt", 32'(o_cnt[0]), 32'd0);
      #1 rst_n = 2'b11;
      chk_en = 1'b1;
      @(posedge clk); #1;

      // ---- two wait states ----
      txn(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rdv, cv, ev);
      check("A write latency", 32'(lat), 32'd3);
      txn(0, 0, 1, 32'h10, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("A read latency", 32'(lat), 32'd3);
      check("A read data", rdv, 32'hDEAD_BEEF);
      check("A cnt after two", 32'(cv), 32'd2);

      txn(0, 1, 0, 32'h10, 32'h1122_3344, 4'b0101, lat, rdv, cv, ev);
      txn(0, 0, 1, 32'h10, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("A byte enable merge", rdv, 32'hDE22_BE44);

      txn(0, 1, 0, 32'h20, 32'hCAFE_0000, 4'hF, lat, rdv, cv, ev);
      t_addr[0] = 32'h20; t_wdata[0] = 32'h5; t_be[0] = 4'hF; t_wen[0] = 1'b1;
      @(posedge clk); #1;
      t_wen[0] = 1'b0;
      nlow = 0;
      repeat (6) begin
         @(negedge clk);
         if (o_busy[0] == 1'b0) nlow++;
      end
      check("A abort busy low cycles", 32'(nlow), 32'd0);
      check("A abort cnt", 32'(o_cnt[0]), 32'd5);
      @(posedge clk); #1;
      txn(0, 0, 1, 32'h20, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("A abort word kept", rdv, 32'hCAFE_0000);
      check("A cnt after abort", 32'(cv), 32'd6);

      txn(0, 0, 1, 32'h400, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("A oor latency", 32'(lat), 32'd3);
      check("A oor rdata", rdv, 32'hBAD1_BAD1);
      check("A oor err", 32'(ev), 32'd1);
      txn(0, 0, 1, 32'h10, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("A err sticky", 32'(ev), 32'd1);
      check("A read after oor", rdv, 32'hDE22_BE44);
      check("A cnt after oor", 32'(cv), 32'd8);

      txn(0, 1, 0, 32'h30, 32'h0BAD_F00D, 4'hF, lat, rdv, cv, ev);
      t_addr[0] = 32'h30; t_wdata[0] = 32'hFFFF_FFFF; t_be[0] = 4'hF; t_wen[0] = 1'b1;
      @(posedge clk);
      #2 rst_n[0] = 1'b0;
      #1;
      check("A reset busy immediate", 32'(o_busy[0]), 32'd1);
      check("A reset cnt immediate", 32'(o_cnt[0]), 32'd0);
      check("A reset err immediate", 32'(o_err[0]), 32'd0);
      t_wen[0] = 1'b0;
      @(negedge clk);
      #2 rst_n[0] = 1'b1;
      @(posedge clk); #1;
      txn(0, 0, 1, 32'h30, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("A mid-wait reset no write", rdv, 32'h0BAD_F00D);
      check("A cnt after reset", 32'(cv), 32'd1);

      // ---- zero wait states, base 0x1000, 16 words ----
      txn(1, 1, 0, 32'h1000, 32'h1234_5678, 4'hF, lat, rdv, cv, ev);
      check("B write latency", 32'(lat), 32'd1);
      rst_n[1] = 1'b0;
      @(negedge clk);
      #2 rst_n[1] = 1'b1;
      @(posedge clk); #1;

      t_addr[1] = 32'h1000; t_ren[1] = 1'b1;
      pat = 5'b10101;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("B back-to-back busy cycle%0d", i), 32'(o_busy[1]), 32'(pat[i]));
         if (i == 1) check("B memory kept over reset", o_rdata[1], 32'h1234_5678);
         if (i == 3) begin
            @(posedge clk); #1;
            t_ren[1] = 1'b0;
         end
      end
      check("B back-to-back cnt", 32'(o_cnt[1]), 32'd2);
      @(posedge clk); #1;

      txn(1, 0, 1, 32'h1003, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("B low addr bits ignored", rdv, 32'h1234_5678);
      txn(1, 1, 0, 32'h1000, 32'hFFFF_FFFF, 4'h0, lat, rdv, cv, ev);
      txn(1, 0, 1, 32'h1000, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("B zero byte enable", rdv, 32'h1234_5678);
      check("B cnt", 32'(cv), 32'd5);
      check("B no err yet", 32'(ev), 32'd0);
      txn(1, 0, 1, 32'h0FFC, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("B below base rdata", rdv, 32'hBAD1_BAD1);
      check("B below base err", 32'(ev), 32'd1);
      txn(1, 0, 1, 32'h1040, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("B above range rdata", rdv, 32'hBAD1_BAD1);

      rst_n[1] = 1'b0;
      @(negedge clk);
      #2 rst_n[1] = 1'b1;
      @(posedge clk); #1;
      txn(1, 1, 1, 32'h1004, 32'hA5A5_A5A5, 4'hF, lat, rdv, cv, ev);
      check("B dual err", 32'(ev), 32'd1);
      check("B dual rdata untouched", rdv, 32'h0);
      txn(1, 0, 1, 32'h1004, 32'h0, 4'h0, lat, rdv, cv, ev);
      check("B dual acts as write", rdv, 32'hA5A5_A5A5);
      check("B cnt after dual", 32'(cv), 32'd2);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
